// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver feeding an ASCII decoder: frames bytes from RxSerial, flags digits and framing errors.
// Latency: AsciiValid 3 cycles after the RxSerial mid-stop-bit point; no backpressure, one-cycle output pulses.
module uart_ascii_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxSerial,
    output logic [7:0] AsciiCode,
    output logic       AsciiValid,
    output logic       IsDigit,
    output logic       FrameErr
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHIGH} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronizer resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxSerial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            AsciiCode  <= 8'h00;
            AsciiValid <= 1'b0;
            IsDigit    <= 1'b0;
            FrameErr   <= 1'b0;
        end else begin
            AsciiValid <= 1'b0;
            FrameErr   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            AsciiCode  <= shreg;
                            AsciiValid <= 1'b1;
                            IsDigit    <= (shreg >= 8'h30) && (shreg <= 8'h39);
                            state      <= IDLE;
                        end else begin
                            FrameErr <= 1'b1;
                            state    <= WAITHIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAITHIGH: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ascii_rx.sv
// Scoreboard bench for uart_ascii_rx at 16 clocks per bit.
module tb_uart_ascii_rx;
    localparam int CPB = 16;

    logic       Clk;
    logic       Rst;
    logic       RxSerial;
    logic [7:0] AsciiCode;
    logic       AsciiValid;
    logic       IsDigit;
    logic       FrameErr;

    int checks   = 0;
    int failures = 0;
    int exp_valid = 0;
    int exp_ferr  = 0;
    int valid_seen = 0;
    int ferr_seen  = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr  = 1'b0;
    logic [7:0] exp_q[$];

    uart_ascii_rx #(.CLKS_PER_BIT(CPB)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RxSerial  (RxSerial),
        .AsciiCode (AsciiCode),
        .AsciiValid(AsciiValid),
        .IsDigit   (IsDigit),
        .FrameErr  (FrameErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid pulse and polices pulse widths.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (AsciiValid) begin
                valid_seen++;
                check("valid_width", {31'd0, prev_valid}, 32'd0);
                check("valid_ferr_overlap", {31'd0, FrameErr}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("ascii_code", {24'd0, AsciiCode}, {24'd0, e});
                    check("is_digit", {31'd0, IsDigit}, {31'd0, (e >= 8'h30 && e <= 8'h39)});
                end
            end
            if (FrameErr) begin
                ferr_seen++;
                check("ferr_width", {31'd0, prev_ferr}, 32'd0);
            end
        end
        prev_valid = AsciiValid;
        prev_ferr  = FrameErr;
    end

    task automatic drive_bit(input logic b);
        RxSerial = b;
        repeat (CPB) @(posedge Clk);
    endtask

    // abort_bit >= 0 pulses Rst halfway through that data bit instead of finishing the frame.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int abort_bit);
        if (abort_bit < 0) begin
            if (stop) begin
                exp_q.push_back(d);
                exp_valid++;
            end else begin
                exp_ferr++;
            end
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                RxSerial = d[i];
                repeat (CPB / 2) @(posedge Clk);
                Rst = 1'b1;
                repeat (3) @(posedge Clk);
                #1;
                check("rst_mid_code", {24'd0, AsciiCode}, 32'd0);
                check("rst_mid_valid", {31'd0, AsciiValid}, 32'd0);
                check("rst_mid_ferr", {31'd0, FrameErr}, 32'd0);
                check("rst_mid_digit", {31'd0, IsDigit}, 32'd0);
                RxSerial = 1'b1;
                @(posedge Clk);
                Rst = 1'b0;
                return;
            end
            drive_bit(d[i]);
        end
        drive_bit(stop);
    endtask

    initial begin
        logic [7:0] saved;
        int vs;
        int fs;
        Rst = 1'b1;
        RxSerial = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("reset_code", {24'd0, AsciiCode}, 32'd0);
        check("reset_valid", {31'd0, AsciiValid}, 32'd0);
        check("reset_digit", {31'd0, IsDigit}, 32'd0);
        check("reset_ferr", {31'd0, FrameErr}, 32'd0);
        Rst = 1'b0;
        repeat (20) @(posedge Clk);

        // Digits back-to-back, no idle gap between frames.
        for (int c = 8'h30; c <= 8'h39; c++) begin
            send_byte(8'(c), 1'b1, -1);
        end
        RxSerial = 1'b1;
        repeat (2 * CPB) @(posedge Clk);
        check("digits_received", valid_seen, 32'd10);

        send_byte(8'h41, 1'b1, -1);
        RxSerial = 1'b1;
        repeat (2 * CPB) @(posedge Clk);
        #1;
        check("a_code", {24'd0, AsciiCode}, 32'h41);
        check("a_digit", {31'd0, IsDigit}, 32'd0);

        // Short low glitch on an idle line.
        saved = AsciiCode;
        vs = valid_seen;
        fs = ferr_seen;
        RxSerial = 1'b0;
        repeat (5) @(posedge Clk);
        RxSerial = 1'b1;
        repeat (4 * CPB) @(posedge Clk);
        #1;
        check("glitch_code", {24'd0, AsciiCode}, {24'd0, saved});
        check("glitch_valid", valid_seen, vs);
        check("glitch_ferr", ferr_seen, fs);

        // Bad stop bit followed by a break.
        vs = valid_seen;
        send_byte(8'h35, 1'b0, -1);
        RxSerial = 1'b0;
        repeat (100) @(posedge Clk);
        RxSerial = 1'b1;
        repeat (2 * CPB) @(posedge Clk);
        #1;
        check("ferr_once", ferr_seen, 32'd1);
        check("ferr_no_valid", valid_seen, vs);
        check("ferr_code_kept", {24'd0, AsciiCode}, 32'h41);
        check("ferr_digit_kept", {31'd0, IsDigit}, 32'd0);
        send_byte(8'h32, 1'b1, -1);
        RxSerial = 1'b1;
        repeat (2 * CPB) @(posedge Clk);
        #1;
        check("after_ferr_code", {24'd0, AsciiCode}, 32'h32);

        // Reset in the middle of bit 4, then a clean frame.
        send_byte(8'h37, 1'b1, 4);
        repeat (3 * CPB) @(posedge Clk);
        #1;
        check("post_rst_code", {24'd0, AsciiCode}, 32'd0);
        send_byte(8'h38, 1'b1, -1);
        RxSerial = 1'b1;
        repeat (2 * CPB) @(posedge Clk);
        #1;
        check("after_rst_code", {24'd0, AsciiCode}, 32'h38);
        check("after_rst_digit", {31'd0, IsDigit}, 32'd1);

        check("valid_total", valid_seen, exp_valid);
        check("ferr_total", ferr_seen, exp_ferr);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
